// File: rtl/rom_memory_pipelined.sv
// Read-only byte memory with a valid/ready request/response handshake, a configurable
// number of wait states and byte/halfword/word little-endian reads with error flagging.
module rom_memory_pipelined #(
    parameter int                  DEPTH       = 512,
    parameter int                  WAIT_STATES = 0,
    // Byte i of the ROM image lives in INIT_IMAGE[8*i +: 8].
    parameter logic [32*DEPTH-1:0] INIT_IMAGE  = '0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [1:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error
);

    localparam int ROM_BYTES = 4 * DEPTH;
    localparam int IDX_W     = $clog2(ROM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [7:0]  rom [ROM_BYTES];

    for (genvar i = 0; i < ROM_BYTES; i++) begin : g_rom
        assign rom[i] = INIT_IMAGE[8*i +: 8];
    end

    // In IDLE the lookup uses the live request so a zero-wait access can register data on accept.
    logic [31:0]      lk_addr;
    logic [1:0]       lk_size;
    logic [2:0]       lk_bytes;
    logic [32:0]      lk_end;
    logic             lk_err;
    logic [IDX_W-1:0] lk_base;
    logic [IDX_W:0]   lane_idx;
    logic [7:0]       lane [4];
    logic [31:0]      lk_data;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        lk_addr  = (state_q == S_IDLE) ? req_address : addr_q;
        lk_size  = (state_q == S_IDLE) ? req_size    : size_q;
        lk_bytes = 3'd0;
        lk_data  = 32'd0;
        lane_idx = '0;
        case (lk_size)
            2'b00:   lk_bytes = 3'd1;
            2'b01:   lk_bytes = 3'd2;
            2'b10:   lk_bytes = 3'd4;
            default: lk_bytes = 3'd0;
        endcase
        lk_end  = {1'b0, lk_addr} + {30'd0, lk_bytes};
        lk_err  = (lk_size == 2'b11)
               || (lk_size == 2'b01 && lk_addr[0])
               || (lk_size == 2'b10 && |lk_addr[1:0])
               || (lk_end > 33'(ROM_BYTES));
        lk_base = lk_err ? '0 : lk_addr[IDX_W-1:0];
        for (int k = 0; k < 4; k++) begin
            lane_idx = {1'b0, lk_base} + (IDX_W+1)'(k);
            lane[k]  = (lane_idx < (IDX_W+1)'(ROM_BYTES)) ? rom[lane_idx[IDX_W-1:0]] : 8'h00;
        end
        case (lk_size)
            2'b00:   lk_data = {24'd0, lane[0]};
            2'b01:   lk_data = {16'd0, lane[1], lane[0]};
            2'b10:   lk_data = {lane[3], lane[2], lane[1], lane[0]};
            default: lk_data = 32'd0;
        endcase
        if (lk_err) lk_data = 32'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_address;
                    size_d = req_size;
                    cnt_d  = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        data_d  = lk_data;
                        err_d   = lk_err;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    data_d  = lk_data;
                    err_d   = lk_err;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_data  = data_q;
        resp_error = err_q;
    end

endmodule

// File: tb/tb_rom_memory_pipelined.sv
// Bench for rom_memory_pipelined: a zero-wait and a three-wait instance share clock and reset;
// expected responses are queued at request time and compared when each response appears.
module tb_rom_memory_pipelined;

    localparam int DEPTH   = 512;
    localparam int NB      = 4 * DEPTH;
    localparam int IW      = 8 * NB;
    localparam int WS_SLOW = 3;
    localparam logic [IW-1:0] IMG = (IW'(32'hEFBEADDE) << (8 * (NB - 4)))
                                  | IW'(64'hA03412B7_00000513);

    logic        clock;
    logic        reset_n;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [31:0] req_address [2];
    logic [1:0]  req_size    [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_data   [2];
    logic        resp_error  [2];

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q [$];

    rom_memory_pipelined #(.DEPTH(DEPTH), .WAIT_STATES(0), .INIT_IMAGE(IMG)) dut_fast (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_address(req_address[0]), .req_size(req_size[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_error(resp_error[0])
    );

    rom_memory_pipelined #(.DEPTH(DEPTH), .WAIT_STATES(WS_SLOW), .INIT_IMAGE(IMG)) dut_slow (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_address(req_address[1]), .req_size(req_size[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_error(resp_error[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance d, then (after `stall` held cycles) complete the handshake.
    task automatic send(input int d, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int stall, input string tag);
        int          lat;
        int          exp_lat;
        logic [32:0] exp;
        exp_lat = (d == 0) ? 1 : WS_SLOW + 1;
        @(negedge clock);
        check({tag, "_ready_idle"}, 32'(req_ready[d]), 32'd1);
        req_valid[d]   = 1'b1;
        req_address[d] = addr;
        req_size[d]    = size;
        sb_q.push_back({exp_err, exp_data});
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        req_valid[d]   = 1'b0;
        req_address[d] = 32'hDEAD_BEEF;
        req_size[d]    = 2'b11;
        while (!resp_valid[d] && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ready_busy"}, 32'(req_ready[d]), 32'd0);
        exp = sb_q.pop_front();
        check({tag, "_data"}, resp_data[d], exp[31:0]);
        check({tag, "_error"}, 32'(resp_error[d]), 32'(exp[32]));
        for (int i = 0; i < stall; i++) begin
            req_valid[d]   = 1'b1;
            req_address[d] = 32'd0;
            req_size[d]    = 2'b10;
            @(negedge clock);
            check({tag, "_stall_valid"}, 32'(resp_valid[d]), 32'd1);
            check({tag, "_stall_data"}, resp_data[d], exp[31:0]);
            check({tag, "_stall_ready"}, 32'(req_ready[d]), 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clock);
        resp_ready[d] = 1'b0;
        check({tag, "_valid_done"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "_ready_done"}, 32'(req_ready[d]), 32'd1);
    endtask

    // Watch for any response on instance d over n cycles after a discarded transaction.
    task automatic expect_quiet(input int d, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check({tag, "_no_stale"}, 32'(resp_valid[d]), 32'd0);
        end
        check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        int lat;
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]   = 1'b0;
            req_address[d] = 32'd0;
            req_size[d]    = 2'b00;
            resp_ready[d]  = 1'b0;
        end
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check("reset_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("reset_resp_data", resp_data[d], 32'd0);
            check("reset_resp_error", 32'(resp_error[d]), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) check("reset_req_ready", 32'(req_ready[d]), 32'd1);

        send(0, 32'd0, 2'b10, 32'h0000_0513, 1'b0, 0, "t1_word0");

        send(1, 32'd7, 2'b00, 32'h0000_00A0, 1'b0, 0, "t2_byte7");
        send(1, 32'd6, 2'b01, 32'h0000_A034, 1'b0, 0, "t2_half6");

        send(1, 32'd1, 2'b01, 32'd0, 1'b1, 0, "t3_half_mis");
        send(1, 32'd2, 2'b10, 32'd0, 1'b1, 0, "t3_word_mis");
        send(1, 32'd0, 2'b11, 32'd0, 1'b1, 0, "t3_size11");

        send(0, 32'd2044,       2'b10, 32'hEFBE_ADDE, 1'b0, 0, "t4_word_last");
        send(0, 32'd2048,       2'b10, 32'd0,         1'b1, 0, "t4_word_over");
        send(0, 32'hFFFF_FFFC,  2'b10, 32'd0,         1'b1, 0, "t4_word_nowrap");
        send(0, 32'd2046,       2'b01, 32'h0000_EFBE, 1'b0, 0, "t4_half_last");
        send(0, 32'd2047,       2'b00, 32'h0000_00EF, 1'b0, 0, "t4_byte_last");
        send(0, 32'd2048,       2'b00, 32'd0,         1'b1, 0, "t4_byte_over");

        send(1, 32'd4, 2'b10, 32'hA034_12B7, 1'b0, 5, "t5_stall");

        // Reset while waiting: the transaction must vanish.
        @(negedge clock);
        req_valid[1]   = 1'b1;
        req_address[1] = 32'd4;
        req_size[1]    = 2'b10;
        @(negedge clock);
        req_valid[1]   = 1'b0;
        check("t6_in_wait", 32'(req_ready[1]), 32'd0);
        #1 reset_n = 1'b0;
        #1 check("t6_wait_rst_valid", 32'(resp_valid[1]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        expect_quiet(1, 8, "t6_wait");

        // Reset while the response is presented.
        @(negedge clock);
        req_valid[1]   = 1'b1;
        req_address[1] = 32'd4;
        req_size[1]    = 2'b10;
        @(negedge clock);
        req_valid[1]   = 1'b0;
        lat = 0;
        while (!resp_valid[1] && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("t6_resp_reached", 32'(resp_valid[1]), 32'd1);
        #1 reset_n = 1'b0;
        #1 check("t6_resp_rst_valid", 32'(resp_valid[1]), 32'd0);
        check("t6_resp_rst_data", resp_data[1], 32'd0);
        check("t6_resp_rst_error", 32'(resp_error[1]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        expect_quiet(1, 8, "t6_resp");

        send(1, 32'd6, 2'b01, 32'h0000_A034, 1'b0, 0, "t6_after");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
